// File: rtl/mac_tile_dual.sv
// mac_tile_dual: systolic-array PE with a double-buffered stationary weight,
// an output-stationary mode fed by streamed weights, and a counted OS drain.
module mac_tile_dual #(
  parameter int bw        = 4,
  parameter int psum_bw   = 16,
  parameter int SAT       = 1,
  parameter int DRAIN_CYC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [1:0]         inst_w,
  output logic [1:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  output logic               out_s_valid,
  input  logic               mode,
  input  logic               w_swap,
  input  logic               drain,
  output logic               busy
);

  localparam int CW = $clog2(DRAIN_CYC) + 1;

  typedef enum logic [1:0] {IDLE, WS, OS_ACC, OS_DRAIN} state_t;

  state_t             state;
  state_t             state_nx;
  logic [bw-1:0]      a_q;
  logic [1:0]         inst_q;
  logic [bw-1:0]      w_bank [0:1];
  logic               act_sel;
  logic               load_ready;
  logic [psum_bw-1:0] c_q;
  logic [bw-1:0]      ws_q;
  logic               drain_pend;
  logic [CW-1:0]      cnt;
  logic               capture;

  // signed(w) * unsigned(a) + c, formed one bit wider than psum so overflow is visible
  function automatic logic [psum_bw-1:0] mac(input logic [bw-1:0] a,
                                             input logic [bw-1:0] w,
                                             input logic [psum_bw-1:0] c);
    logic signed [2*bw:0]   prod;
    logic signed [psum_bw:0] sum;
    prod = (2*bw+1)'($signed(w)) * (2*bw+1)'($signed({1'b0, a}));
    sum  = (psum_bw+1)'(prod) + (psum_bw+1)'($signed(c));
    if (SAT != 0 && (sum[psum_bw] != sum[psum_bw-1]))
      return sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return sum[psum_bw-1:0];
  endfunction

  assign out_e   = a_q;
  assign inst_e  = inst_q;
  assign capture = inst_w[0] & load_ready;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state selection and south-facing outputs
  always_comb begin
    state_nx    = state;
    out_s       = '0;
    out_s_valid = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: state_nx = mode ? OS_ACC : WS;
      WS: begin
        out_s       = mac(a_q, w_bank[act_sel], c_q);
        out_s_valid = inst_q[1];
        if (mode && (inst_w == 2'b00)) state_nx = OS_ACC;
      end
      OS_ACC: begin
        out_s = {{(psum_bw-bw){ws_q[bw-1]}}, ws_q};
        if (drain_pend && !inst_w[1]) state_nx = OS_DRAIN;
      end
      OS_DRAIN: begin
        out_s       = c_q;
        out_s_valid = 1'b1;
        busy        = 1'b1;
        if (cnt == CW'(DRAIN_CYC - 1)) state_nx = mode ? OS_ACC : WS;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath, weight double buffer and drain bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      inst_q     <= '0;
      w_bank[0]  <= '0;
      w_bank[1]  <= '0;
      act_sel    <= 1'b0;
      load_ready <= 1'b1;
      c_q        <= '0;
      ws_q       <= '0;
      drain_pend <= 1'b0;
      cnt        <= '0;
    end else begin
      // A load pulse is forwarded east only when this tile has already
      // captured; with load_ready high it is either consumed or absent.
      inst_q <= (state == OS_DRAIN) ? 2'b00 : {inst_w[1], inst_w[0] & ~load_ready};

      case (state)
        WS: begin
          c_q <= (state_nx == OS_ACC) ? '0 : in_n;
          if (inst_w != 2'b00) a_q <= in_w;
        end
        OS_ACC: begin
          ws_q <= in_n[bw-1:0];
          if (inst_w[1]) begin
            a_q <= in_w;
            c_q <= mac(in_w, in_n[bw-1:0], c_q);
          end
          if (state_nx == OS_DRAIN) begin
            cnt        <= '0;
            drain_pend <= 1'b0;
          end else if (drain) begin
            drain_pend <= 1'b1;
          end
        end
        OS_DRAIN: begin
          c_q <= (state_nx != OS_DRAIN) ? '0 : in_n;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase

      // capture goes to the current shadow slot; a same-cycle swap makes it active
      if (state != OS_DRAIN) begin
        if (capture) w_bank[~act_sel] <= in_w;
        if (w_swap) begin
          act_sel    <= ~act_sel;
          load_ready <= 1'b1;
        end else if (capture) begin
          load_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_tile_dual.sv
// Bench for mac_tile_dual: two tiles (saturating and wrapping, 8-bit psum,
// 4-cycle drain) share stimulus and are compared against an integer model.
module tb_mac_tile_dual;

  localparam int BW = 4;
  localparam int PB = 8;
  localparam int DC = 4;
  localparam int P_IDLE = 0, P_WS = 1, P_OS = 2, P_DR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] in_w;
  logic [1:0]    inst_w;
  logic [PB-1:0] in_n;
  logic          mode, w_swap, drain;

  logic [BW-1:0] s_out_e, w_out_e;
  logic [1:0]    s_inst_e, w_inst_e;
  logic [PB-1:0] s_out_s, w_out_s;
  logic          s_valid, w_valid, s_busy, w_busy;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model, index 0 = saturating tile, 1 = wrapping tile
  int ph [2], a [2], c [2], wsv [2], pend [2], cnt [2], lr [2], sel [2], iq [2];
  int wb [2][2];

  always #5 clk = ~clk;

  mac_tile_dual #(.bw(BW), .psum_bw(PB), .SAT(1), .DRAIN_CYC(DC)) u_sat (
    .clk(clk), .reset(reset), .in_w(in_w), .out_e(s_out_e), .inst_w(inst_w),
    .inst_e(s_inst_e), .in_n(in_n), .out_s(s_out_s), .out_s_valid(s_valid),
    .mode(mode), .w_swap(w_swap), .drain(drain), .busy(s_busy));

  mac_tile_dual #(.bw(BW), .psum_bw(PB), .SAT(0), .DRAIN_CYC(DC)) u_wrap (
    .clk(clk), .reset(reset), .in_w(in_w), .out_e(w_out_e), .inst_w(inst_w),
    .inst_e(w_inst_e), .in_n(in_n), .out_s(w_out_s), .out_s_valid(w_valid),
    .mode(mode), .w_swap(w_swap), .drain(drain), .busy(w_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx8(input int v);
    int r;
    r = v & 255;
    return (r >= 128) ? r - 256 : r;
  endfunction

  function automatic int macf(input int act, input int w4, input int acc, input bit sat);
    int w, p;
    w = (w4 >= 8) ? w4 - 16 : w4;
    p = w * act + acc;
    if (sat) begin
      if (p > 127)  p = 127;
      if (p < -128) p = -128;
      return p;
    end
    return sx8(p);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE; a[k] = 0; c[k] = 0; wsv[k] = 0; pend[k] = 0; cnt[k] = 0;
      lr[k] = 1; sel[k] = 0; iq[k] = 0; wb[k][0] = 0; wb[k][1] = 0;
    end
  endtask

  task automatic model_step();
    int o_ph, o_lr, o_sel, o_pend, o_cnt, o_c;
    bit cap;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      o_ph = ph[k]; o_lr = lr[k]; o_sel = sel[k]; o_pend = pend[k]; o_cnt = cnt[k]; o_c = c[k];
      case (o_ph)
        P_IDLE: ph[k] = mode ? P_OS : P_WS;
        P_WS: begin
          c[k] = sx8(int'(in_n));
          if (inst_w != 2'b00) a[k] = int'(in_w);
          if (mode && inst_w == 2'b00) begin ph[k] = P_OS; c[k] = 0; end
        end
        P_OS: begin
          wsv[k] = int'(in_n[3:0]);
          if (inst_w[1]) begin
            a[k] = int'(in_w);
            c[k] = macf(int'(in_w), int'(in_n[3:0]), o_c, k == 0);
          end
          if (o_pend != 0 && !inst_w[1]) begin ph[k] = P_DR; cnt[k] = 0; pend[k] = 0; end
          else if (drain) pend[k] = 1;
        end
        default: begin
          c[k] = sx8(int'(in_n));
          cnt[k] = o_cnt + 1;
          if (o_cnt == DC - 1) begin c[k] = 0; ph[k] = mode ? P_OS : P_WS; end
        end
      endcase
      if (o_ph != P_DR) begin
        cap = inst_w[0] && (o_lr != 0);
        if (cap) wb[k][1-o_sel] = int'(in_w);
        if (w_swap) begin sel[k] = 1 - o_sel; lr[k] = 1; end
        else if (cap) lr[k] = 0;
        iq[k] = (inst_w[1] ? 2 : 0) + ((inst_w[0] && o_lr == 0) ? 1 : 0);
      end else begin
        iq[k] = 0;
      end
    end
  endtask

  task automatic check_dut(input int k, input logic [3:0] oe, input logic [1:0] ie,
                           input logic [7:0] os, input logic ov, input logic b);
    int eos, eov;
    string p;
    p = (k == 0) ? "sat" : "wrap";
    case (ph[k])
      P_WS:    begin eos = macf(a[k], wb[k][sel[k]], c[k], k == 0) & 255; eov = iq[k] >> 1; end
      P_OS:    begin eos = sx8((wsv[k] >= 8) ? wsv[k] - 16 : wsv[k]) & 255; eov = 0; end
      P_DR:    begin eos = c[k] & 255; eov = 1; end
      default: begin eos = 0; eov = 0; end
    endcase
    check({p, "_out_e"},  32'(oe), 32'(a[k]));
    check({p, "_inst_e"}, 32'(ie), 32'(iq[k]));
    check({p, "_out_s"},  32'(os), 32'(eos));
    check({p, "_valid"},  32'(ov), 32'(eov));
    check({p, "_busy"},   32'(b),  32'(ph[k] == P_DR));
  endtask

  task automatic check_all();
    check_dut(0, s_out_e, s_inst_e, s_out_s, s_valid, s_busy);
    check_dut(1, w_out_e, w_inst_e, w_out_s, w_valid, w_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [1:0] ii, input logic [3:0] iw, input logic [7:0] nn,
                       input logic sw, input logic dr);
    inst_w = ii; in_w = iw; in_n = nn; w_swap = sw; drain = dr;
  endtask

  initial begin
    int av [4];
    int wv [4];
    av = '{1, 2, 3, 15};
    wv = '{1, 2, 3, 7};
    reset = 1'b0; mode = 1'b0;
    drive(2'b00, 4'd0, 8'd0, 1'b0, 1'b0);
    model_reset();
    tick(); tick();
    check("rst_out_s", 32'(s_out_s), 32'd0);
    reset = 1'b1;
    tick();

    // WS: load 3, swap, execute 5 with psum 10
    drive(2'b01, 4'd3, 8'd0, 1'b0, 1'b0); tick();
    check("load_consumed", 32'(s_inst_e), 32'd0);
    drive(2'b00, 4'd0, 8'd0, 1'b1, 1'b0); tick();
    drive(2'b10, 4'd5, 8'd10, 1'b0, 1'b0); tick();
    check("ws_mac", 32'(s_out_s), 32'd25);
    check("ws_valid", 32'(s_valid), 32'd1);
    check("ws_inst_e", 32'(s_inst_e), 32'd2);

    // double buffer: active -2, shadow 7
    drive(2'b01, 4'hE, 8'd0, 1'b0, 1'b0); tick();
    drive(2'b00, 4'd0, 8'd0, 1'b1, 1'b0); tick();
    drive(2'b01, 4'd7, 8'd0, 1'b0, 1'b0); tick();
    drive(2'b10, 4'd4, 8'd0, 1'b0, 1'b0); tick();
    check("db_active", 32'(s_out_s), 32'hF8);
    drive(2'b00, 4'd0, 8'd0, 1'b1, 1'b0); tick();
    drive(2'b10, 4'd4, 8'd0, 1'b0, 1'b0); tick();
    check("db_swapped", 32'(s_out_s), 32'd28);

    // second load without swap is forwarded east
    drive(2'b01, 4'd9, 8'd0, 1'b0, 1'b0); tick();
    check("load1_inst_e", 32'(s_inst_e), 32'd0);
    drive(2'b01, 4'd2, 8'd0, 1'b0, 1'b0); tick();
    check("load2_fwd", 32'(s_inst_e), 32'd1);

    // OS accumulate to 119
    drive(2'b00, 4'd0, 8'd0, 1'b0, 1'b0); mode = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 4'(av[i]), 8'(wv[i]), 1'b0, 1'b0); tick();
      check("os_stream_w", 32'(s_out_s), 32'(wv[i]));
    end
    drive(2'b10, 4'd0, 8'd0, 1'b0, 1'b1); tick();
    check("drain_deferred", 32'(s_busy), 32'd0);
    drive(2'b00, 4'd0, 8'd0, 1'b0, 1'b0); tick();
    check("drain_first", 32'(s_out_s), 32'd119);
    check("drain_busy", 32'(s_busy), 32'd1);
    for (int v = 1; v <= 4; v++) begin
      drive(2'b00, 4'd0, 8'(v), 1'b0, 1'b0); tick();
      if (v < 4) check("drain_chain", 32'(s_out_s), 32'(v));
      else       check("drain_done", 32'(s_busy), 32'd0);
    end

    // saturation vs wrap: 120 + 105
    drive(2'b10, 4'd15, 8'd1, 1'b0, 1'b0); tick();
    drive(2'b10, 4'd15, 8'd7, 1'b0, 1'b0); tick();
    drive(2'b10, 4'd15, 8'd7, 1'b0, 1'b0); tick();
    drive(2'b10, 4'd0, 8'd0, 1'b0, 1'b1); tick();
    drive(2'b00, 4'd0, 8'd0, 1'b0, 1'b0); tick();
    check("sat_clamp", 32'(s_out_s), 32'h7F);
    check("wrap_result", 32'(w_out_s), 32'hE1);
    for (int i = 0; i < DC; i++) tick();

    // asynchronous reset in the middle of a drain
    drive(2'b10, 4'd0, 8'd0, 1'b0, 1'b1); tick();
    drive(2'b00, 4'd0, 8'd5, 1'b0, 1'b0); tick(); tick();
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", 32'(s_busy), 32'd0);
    check("midrst_out_s", 32'(s_out_s), 32'd0);
    check_all();
    tick();
    reset = 1'b1; mode = 1'b0;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
